// File: rtl/msrv32_operand_issue_if.sv
// Decode-to-ALU bundle for the operand issue stage: decode handshake, writeback port
// and the registered ALU operand outputs with the stall monitor.
interface msrv32_operand_issue_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
);
  logic                 dec_valid_in;
  logic                 dec_ready_out;
  logic [4:0]           rs1_addr_in;
  logic [4:0]           rs2_addr_in;
  logic [4:0]           rd_addr_in;
  logic                 rd_wr_req_in;
  logic [WIDTH-1:0]     pc_in;
  logic [WIDTH-1:0]     imm_in;
  logic                 op1_sel_in;
  logic                 op2_sel_in;
  logic [3:0]           alu_opcode_in;
  logic                 flush_in;
  logic                 wb_en_in;
  logic [4:0]           wb_addr_in;
  logic [WIDTH-1:0]     wb_data_in;
  logic                 alu_valid_out;
  logic                 alu_ready_in;
  logic [WIDTH-1:0]     op_1_out;
  logic [WIDTH-1:0]     op_2_out;
  logic [3:0]           opcode_out;
  logic [4:0]           rd_addr_out;
  logic                 rd_wr_en_out;
  logic [CNT_WIDTH-1:0] stall_count_out;

  modport slave (
    input  dec_valid_in, rs1_addr_in, rs2_addr_in, rd_addr_in, rd_wr_req_in,
    input  pc_in, imm_in, op1_sel_in, op2_sel_in, alu_opcode_in, flush_in,
    input  wb_en_in, wb_addr_in, wb_data_in, alu_ready_in,
    output dec_ready_out, alu_valid_out, op_1_out, op_2_out, opcode_out,
    output rd_addr_out, rd_wr_en_out, stall_count_out
  );

  modport master (
    output dec_valid_in, rs1_addr_in, rs2_addr_in, rd_addr_in, rd_wr_req_in,
    output pc_in, imm_in, op1_sel_in, op2_sel_in, alu_opcode_in, flush_in,
    output wb_en_in, wb_addr_in, wb_data_in, alu_ready_in,
    input  dec_ready_out, alu_valid_out, op_1_out, op_2_out, opcode_out,
    input  rd_addr_out, rd_wr_en_out, stall_count_out
  );
endinterface

// File: rtl/msrv32_operand_issue.sv
// Operand issue stage: register file with writeback bypass, operand select and a
// one-entry valid/ready register towards the ALU, plus a saturating stall counter.
module msrv32_operand_issue #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                   ms_riscv32_mp_clk_in,
  input  logic                   ms_riscv32_mp_rst_in,
  msrv32_operand_issue_if.slave  bus
);

  logic [WIDTH-1:0]     r_regs [0:31];
  logic                 r_alu_valid;
  logic [WIDTH-1:0]     r_op_1;
  logic [WIDTH-1:0]     r_op_2;
  logic [3:0]           r_opcode;
  logic [4:0]           r_rd_addr;
  logic                 r_rd_wr_en;
  logic [CNT_WIDTH-1:0] r_stall_count;

  logic [WIDTH-1:0]     w_rs1_val;
  logic [WIDTH-1:0]     w_rs2_val;
  logic [WIDTH-1:0]     w_op_1;
  logic [WIDTH-1:0]     w_op_2;
  logic                 w_dec_ready;
  logic                 w_fire;
  logic                 w_stall;

  // Register reads; a same-cycle writeback to the source index bypasses the array.
  always_comb begin
    w_rs1_val = {WIDTH{1'b0}};
    w_rs2_val = {WIDTH{1'b0}};
    if (bus.rs1_addr_in == 5'd0) begin
      w_rs1_val = {WIDTH{1'b0}};
    end else if (bus.wb_en_in && (bus.wb_addr_in == bus.rs1_addr_in)) begin
      w_rs1_val = bus.wb_data_in;
    end else begin
      w_rs1_val = r_regs[bus.rs1_addr_in];
    end
    if (bus.rs2_addr_in == 5'd0) begin
      w_rs2_val = {WIDTH{1'b0}};
    end else if (bus.wb_en_in && (bus.wb_addr_in == bus.rs2_addr_in)) begin
      w_rs2_val = bus.wb_data_in;
    end else begin
      w_rs2_val = r_regs[bus.rs2_addr_in];
    end
  end

  assign w_op_1      = bus.op1_sel_in ? bus.pc_in  : w_rs1_val;
  assign w_op_2      = bus.op2_sel_in ? bus.imm_in : w_rs2_val;
  assign w_dec_ready = !ms_riscv32_mp_rst_in && (!r_alu_valid || bus.alu_ready_in);
  assign w_fire      = bus.dec_valid_in && w_dec_ready && !bus.flush_in;
  assign w_stall     = r_alu_valid && !bus.alu_ready_in && !bus.flush_in;

  // Register file, issue register and stall counter; flush outranks capture and hold.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= {WIDTH{1'b0}};
      end
      r_alu_valid   <= 1'b0;
      r_op_1        <= {WIDTH{1'b0}};
      r_op_2        <= {WIDTH{1'b0}};
      r_opcode      <= 4'd0;
      r_rd_addr     <= 5'd0;
      r_rd_wr_en    <= 1'b0;
      r_stall_count <= {CNT_WIDTH{1'b0}};
    end else begin
      if (bus.wb_en_in && (bus.wb_addr_in != 5'd0)) begin
        r_regs[bus.wb_addr_in] <= bus.wb_data_in;
      end
      if (bus.flush_in) begin
        r_alu_valid <= 1'b0;
      end else if (w_fire) begin
        r_alu_valid <= 1'b1;
        r_op_1      <= w_op_1;
        r_op_2      <= w_op_2;
        r_opcode    <= bus.alu_opcode_in;
        r_rd_addr   <= bus.rd_addr_in;
        r_rd_wr_en  <= bus.rd_wr_req_in;
      end else if (bus.alu_ready_in) begin
        r_alu_valid <= 1'b0;
      end
      if (w_stall && (r_stall_count != {CNT_WIDTH{1'b1}})) begin
        r_stall_count <= r_stall_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
    end
  end

  assign bus.dec_ready_out   = w_dec_ready;
  assign bus.alu_valid_out   = r_alu_valid;
  assign bus.op_1_out        = r_op_1;
  assign bus.op_2_out        = r_op_2;
  assign bus.opcode_out      = r_opcode;
  assign bus.rd_addr_out     = r_rd_addr;
  assign bus.rd_wr_en_out    = r_rd_wr_en;
  assign bus.stall_count_out = r_stall_count;

endmodule

// File: doc/msrv32_operand_issue.md
Name: msrv32_operand_issue

Overview:
Issue stage directly upstream of the ALU. It holds the 32-entry integer register file and reads rs1/rs2 with same-cycle writeback bypass. It selects ALU operands (rs1 or PC, rs2 or immediate) and registers operand 1, operand 2 and the 4-bit ALU opcode into a one-entry valid/ready pipeline register that feeds the ALU. It also counts ALU back-pressure cycles for performance monitoring.

Parameters:
WIDTH, 32, data/register width (ALU operand width)
CNT_WIDTH, 32, width of stall counter

Ports:
ms_riscv32_mp_clk_in  input  1  clock, all state on rising edge
ms_riscv32_mp_rst_in  input  1  synchronous active-high reset
dec_valid_in  input  1  decoded instruction valid
dec_ready_out  output  1  stage can accept instruction this cycle
rs1_addr_in  input  5  source register 1 index
rs2_addr_in  input  5  source register 2 index
rd_addr_in  input  5  destination index
rd_wr_req_in  input  1  instruction writes rd
pc_in  input  WIDTH  instruction PC
imm_in  input  WIDTH  sign-extended immediate
op1_sel_in  input  1  0: rs1 value, 1: pc_in
op2_sel_in  input  1  0: rs2 value, 1: imm_in
alu_opcode_in  input  4  ALU opcode (ADD 0000, SUB 1000, SLT 0010, SLTU 0011, AND 0111, OR 0110, XOR 0100, SLL 0001, SRL 0101, SRA 1101)
flush_in  input  1  discard held and incoming instruction
wb_en_in  input  1  writeback enable
wb_addr_in  input  5  writeback index
wb_data_in  input  WIDTH  writeback data
alu_valid_out  output  1  operands valid to ALU
alu_ready_in  input  1  ALU/downstream consumes this cycle
op_1_out  output  WIDTH  ALU operand 1
op_2_out  output  WIDTH  ALU operand 2
opcode_out  output  4  ALU opcode
rd_addr_out  output  5  destination index
rd_wr_en_out  output  1  destination write request
stall_count_out  output  CNT_WIDTH  cycles with alu_valid_out=1, alu_ready_in=0

Behaviour:
- Reset (sync, rst=1 at edge): all 32 registers, alu_valid_out, op_1_out, op_2_out, opcode_out, rd_addr_out, rd_wr_en_out and stall_count_out go to 0. dec_ready_out=0 while rst is high.
- Register file: write at edge when wb_en_in=1 and wb_addr_in!=0. Writes to x0 are ignored. x0 always reads 0.
- Read: combinational. If wb_en_in=1, wb_addr_in==rsN and rsN!=0, the read returns wb_data_in (bypass). Otherwise it returns the stored value.
- Operand mux: op1 = op1_sel_in ? pc_in : rs1 value. op2 = op2_sel_in ? imm_in : rs2 value. No width change.
- dec_ready_out = !rst & (!alu_valid_out | alu_ready_in). It is combinational and must not depend on dec_valid_in.
- Capture (fire) = dec_valid_in & dec_ready_out & !flush_in. On fire: op_1_out, op_2_out, opcode_out, rd_addr_out and rd_wr_en_out load; alu_valid_out becomes 1 next cycle. Latency is 1 cycle from accept to alu_valid_out.
- No fire and alu_ready_in=1: alu_valid_out goes to 0. Data registers hold their values (don't-care).
- alu_valid_out=1 and alu_ready_in=0: all outputs hold stable until consumed.
- Back-to-back: accept and consume in the same cycle keeps alu_valid_out=1 with new data. Full throughput is 1 instruction per cycle.
- flush_in=1: alu_valid_out goes to 0 next cycle and the incoming instruction is dropped. Flush has priority over fire and hold.
- Flush does not block writeback: the register file write still occurs.
- Operands are sampled at capture. A later writeback does not update a held instruction; RAW across in-flight instructions is handled by downstream forwarding.
- Stall counter: increments each cycle alu_valid_out=1 & alu_ready_in=0 & !flush_in. It saturates at all-ones and clears only on reset.

Test Plan:
- Reset then write x5=0x0000_1234 and x6=0xFFFF_FFF0. Issue rs1=5, rs2=6, op2_sel=0, opcode=0000 -> next cycle alu_valid_out=1, op_1_out=0x1234, op_2_out=0xFFFFFFF0, opcode_out=0000.
- Write x0=0xDEADBEEF, then issue rs1=0, rs2=0 -> op_1_out=op_2_out=0. Same-cycle wb x7=0xA5A5A5A5 with rs1=7 -> op_1_out=0xA5A5A5A5.
- op1_sel=1, pc=0x0000_0100, op2_sel=1, imm=0xFFFF_FFFC, opcode=1000 -> op_1_out=0x100, op_2_out=0xFFFFFFFC, opcode_out=1000, rd_wr_en_out follows rd_wr_req_in.
- Hold alu_ready_in=0 for 3 cycles with valid held -> dec_ready_out=0, outputs unchanged, stall_count_out=3. Release -> a queued instruction issues the same cycle; the stream then continues at 1 per cycle with no bubble.
- flush_in=1 with valid held and dec_valid_in=1 -> alu_valid_out=0 next cycle and no capture. A wb issued in the flush cycle is readable afterwards.
- Assert rst mid-stall -> all outputs 0 and registers read 0 after the edge. dec_ready_out=0 during reset and 1 the cycle after.
